fpu_man_alu_pipe: RTL and testbench

- Parametrised, pipelined successor to the single-cycle mantissa add/sub ALU used in FPU_ADD_SUB.
- Takes aligned max/min mantissas plus operand signs and op, resolves effective add/sub, applies zero-operand bypass, and returns the raw mantissa sum with a carry-out overflow flag.
- Adds a valid/ready handshake and a configurable register depth so it can sit between the alignment shifter and the normaliser in the FFT butterfly datapath at higher clock rates.

---
 rtl/fpu_man_alu_pipe.sv | 210 +++++++++++++++++++++
 tb/tb_fpu_man_alu_pipe.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_man_alu_pipe.sv
// -----------------------------------------------------------------------------
// fpu_man_alu_pipe
//
// Pipelined mantissa add/sub ALU for the floating-point add/sub datapath.
// Takes the aligned larger and smaller mantissas with their signs and the
// requested op, and resolves the effective operation from op and signs. It
// applies a zero-operand bypass and returns the raw mantissa result together
// with the carry-out of an effective add. Stage 1 computes and registers the
// result. Stages 2..NUM_STAGE are plain delay registers. Every stage has its
// own valid bit and ready/valid flow control, so the block can stall without
// losing, duplicating or reordering beats.
//
// Parameters:
//   SIZE_MAN   mantissa width including hidden bit (8..64)
//   NUM_STAGE  register stages from input to output (1..4)
//   NUM_OP     op-select width; only bit 0 is used (0 = ADD, 1 = SUB)
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_valid / o_ready       input handshake
//   i_fpu_op                requested operation
//   i_sign_a, i_sign_b      signs of the max / min operand
//   i_carry                 alignment borrow; suppresses the +1 of the subtract
//   i_E_zero_A, i_E_zero_B  exponent-is-zero flags of max / min operand
//   i_man_max, i_man_min    aligned larger / smaller mantissa
//   o_valid / i_ready       output handshake
//   o_man_alu               result mantissa
//   o_overflow              carry-out of an effective add
//   o_eff_sub               beat was an effective subtraction
//   o_lzc                   leading-zero count of o_man_alu
//
// Optional feature (macro FPU_MAN_ALU_LZC_EN):
//   defined   - a leading-zero count of the stage-1 result is registered with
//               it and travels down the pipe with its beat.
//   undefined - no LZC logic is built and o_lzc is tied to 0.
// -----------------------------------------------------------------------------
module fpu_man_alu_pipe #(
    parameter  int SIZE_MAN  = 24,
    parameter  int NUM_STAGE = 2,
    parameter  int NUM_OP    = 1,
    localparam int LZC_W     = $clog2(SIZE_MAN + 1)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [NUM_OP-1:0]   i_fpu_op,
    input  logic                i_sign_a,
    input  logic                i_sign_b,
    input  logic                i_carry,
    input  logic                i_E_zero_A,
    input  logic                i_E_zero_B,
    input  logic [SIZE_MAN-1:0] i_man_max,
    input  logic [SIZE_MAN-1:0] i_man_min,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [SIZE_MAN-1:0] o_man_alu,
    output logic                o_overflow,
    output logic                o_eff_sub,
    output logic [LZC_W-1:0]    o_lzc
);

`ifdef FPU_MAN_ALU_LZC_EN
    typedef struct packed {
        logic [SIZE_MAN-1:0] man;
        logic                ovf;
        logic                eff_sub;
        logic [LZC_W-1:0]    lzc;
    } beat_t;

    // Count of leading zeros; an all-zero value reports SIZE_MAN.
    function automatic logic [LZC_W-1:0] lzc_count(input logic [SIZE_MAN-1:0] v);
        logic found;
        lzc_count = LZC_W'(SIZE_MAN);
        found     = 1'b0;
        for (int i = SIZE_MAN - 1; i >= 0; i--) begin
            if (!found && v[i]) begin
                lzc_count = LZC_W'(SIZE_MAN - 1 - i);
                found     = 1'b1;
            end
        end
    endfunction
`else
    typedef struct packed {
        logic [SIZE_MAN-1:0] man;
        logic                ovf;
        logic                eff_sub;
    } beat_t;
`endif

    // ---------------------------------------------------------------------
    // Stage-1 combinational datapath
    // ---------------------------------------------------------------------
    logic                eff_sub;
    logic                z_a;
    logic                z_b;
    logic [SIZE_MAN-1:0] min_op;
    logic [SIZE_MAN:0]   sum_ext;
    beat_t               beat_d;

    // NOTE: every variable written here gets a value before any branch,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        eff_sub = i_fpu_op[0] ^ i_sign_a ^ i_sign_b;
        z_a     = i_E_zero_A & (i_man_max[SIZE_MAN-2:0] == '0);
        z_b     = i_E_zero_B & (i_man_min[SIZE_MAN-2:0] == '0);

        // Subtract is max + ~min + 1. An alignment borrow drops the +1.
        min_op  = eff_sub ? ~i_man_min : i_man_min;
        sum_ext = {1'b0, i_man_max} + {1'b0, min_op}
                + (SIZE_MAN + 1)'(eff_sub & ~i_carry);

        beat_d         = '0;
        beat_d.eff_sub = eff_sub;
        if (z_a) begin
            beat_d.man = i_man_min;
        end else if (z_b) begin
            beat_d.man = i_man_max;
        end else begin
            beat_d.man = sum_ext[SIZE_MAN-1:0];
            // The carry-out of a subtract is only the borrow complement.
            beat_d.ovf = ~eff_sub & sum_ext[SIZE_MAN];
        end
`ifdef FPU_MAN_ALU_LZC_EN
        beat_d.lzc = lzc_count(beat_d.man);
`endif
    end

    // ---------------------------------------------------------------------
    // Pipeline registers and flow control
    // ---------------------------------------------------------------------
    logic [NUM_STAGE-1:0] stg_valid;
    logic [NUM_STAGE-1:0] stg_rdy;
    logic [NUM_STAGE-1:0] prev_valid;
    beat_t                stg_data  [NUM_STAGE];
    beat_t                prev_data [NUM_STAGE];
    logic                 ready_en;
    logic                 in_fire;

    // A stage may load when it, or any stage after it, is empty, or when
    // the downstream consumer accepts. The chain is built from the output
    // back, so o_ready sees i_ready in the same cycle and there is no bubble.
    always_comb begin
        logic acc;
        // NOTE: blocking assignments model combinational logic; acc is a
        // running temporary read back within this same pass.
        acc     = i_ready;
        stg_rdy = '0;
        for (int k = NUM_STAGE - 1; k >= 0; k--) begin
            acc        = acc | ~stg_valid[k];
            stg_rdy[k] = acc;
        end
    end

    // Holds o_ready low until the first clock after reset is released.
    assign o_ready = ready_en & stg_rdy[0];
    assign in_fire = i_valid & o_ready;

    // What each stage would load: the new beat for stage 1, or the
    // predecessor's contents for the delay stages.
    always_comb begin
        prev_valid    = '0;
        prev_valid[0] = in_fire;
        prev_data[0]  = beat_d;
        for (int k = 1; k < NUM_STAGE; k++) begin
            prev_valid[k] = stg_valid[k-1];
            prev_data[k]  = stg_data[k-1];
        end
    end

    // NOTE: the data registers are reset as well as the valid bits, because
    // the output fields must read zero during and after reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ready_en  <= 1'b0;
            stg_valid <= '0;
            for (int k = 0; k < NUM_STAGE; k++) begin
                stg_data[k] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments, so every stage samples its
            // predecessor's value from before this edge.
            ready_en <= 1'b1;
            for (int k = 0; k < NUM_STAGE; k++) begin
                if (stg_rdy[k]) begin
                    stg_valid[k] <= prev_valid[k];
                    // Data only moves with a valid beat. Idle cycles leave
                    // the last value in place.
                    if (prev_valid[k]) begin
                        stg_data[k] <= prev_data[k];
                    end
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign o_valid    = stg_valid[NUM_STAGE-1];
    assign o_man_alu  = stg_data[NUM_STAGE-1].man;
    assign o_overflow = stg_data[NUM_STAGE-1].ovf;
    assign o_eff_sub  = stg_data[NUM_STAGE-1].eff_sub;
`ifdef FPU_MAN_ALU_LZC_EN
    assign o_lzc      = stg_data[NUM_STAGE-1].lzc;
`else
    assign o_lzc      = '0;
`endif

endmodule

// File: tb/tb_fpu_man_alu_pipe.sv
// -----------------------------------------------------------------------------
// tb_fpu_man_alu_pipe
//
// Scoreboard bench for fpu_man_alu_pipe. The stimulus tasks push a
// hand-computed expected beat into a queue at each input handshake. An
// independent monitor pops and compares whenever an output beat transfers.
// -----------------------------------------------------------------------------
module tb_fpu_man_alu_pipe;

    localparam int SIZE_MAN  = 24;
    localparam int NUM_STAGE = 2;
    localparam int NUM_OP    = 1;
    localparam int LZC_W     = $clog2(SIZE_MAN + 1);

    logic                i_clk;
    logic                i_rst_n;
    logic                i_valid;
    logic                o_ready;
    logic [NUM_OP-1:0]   i_fpu_op;
    logic                i_sign_a;
    logic                i_sign_b;
    logic                i_carry;
    logic                i_E_zero_A;
    logic                i_E_zero_B;
    logic [SIZE_MAN-1:0] i_man_max;
    logic [SIZE_MAN-1:0] i_man_min;
    logic                o_valid;
    logic                i_ready;
    logic [SIZE_MAN-1:0] o_man_alu;
    logic                o_overflow;
    logic                o_eff_sub;
    logic [LZC_W-1:0]    o_lzc;

    fpu_man_alu_pipe #(
        .SIZE_MAN  (SIZE_MAN),
        .NUM_STAGE (NUM_STAGE),
        .NUM_OP    (NUM_OP)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_fpu_op   (i_fpu_op),
        .i_sign_a   (i_sign_a),
        .i_sign_b   (i_sign_b),
        .i_carry    (i_carry),
        .i_E_zero_A (i_E_zero_A),
        .i_E_zero_B (i_E_zero_B),
        .i_man_max  (i_man_max),
        .i_man_min  (i_man_min),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_man_alu  (o_man_alu),
        .o_overflow (o_overflow),
        .o_eff_sub  (o_eff_sub),
        .o_lzc      (o_lzc)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        logic [SIZE_MAN-1:0] man;
        logic                ovf;
        logic                es;
        logic [LZC_W-1:0]    lzc;
        int                  t_hs;
        bit                  lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_hs     = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one beat and hold it until the handshake. Push the expected
    // result at the handshake. Called #1 after a rising edge; returns #1
    // after the handshake edge with i_valid still high.
    task automatic send(input logic op, input logic sa, input logic sgb, input logic carry,
                        input logic eza, input logic ezb,
                        input logic [SIZE_MAN-1:0] mx, input logic [SIZE_MAN-1:0] mn,
                        input logic [SIZE_MAN-1:0] e_man, input logic e_ovf, input logic e_es,
                        input logic [LZC_W-1:0] e_lz, input bit lat);
        exp_t e;
        int   tries;
        i_valid    = 1'b1;
        i_fpu_op   = op;
        i_sign_a   = sa;
        i_sign_b   = sgb;
        i_carry    = carry;
        i_E_zero_A = eza;
        i_E_zero_B = ezb;
        i_man_max  = mx;
        i_man_min  = mn;
        tries      = 0;
        forever begin
            @(negedge i_clk);
            if (o_ready) begin
                e.man  = e_man;
                e.ovf  = e_ovf;
                e.es   = e_es;
`ifdef FPU_MAN_ALU_LZC_EN
                e.lzc  = e_lz;
`else
                e.lzc  = '0;
`endif
                e.t_hs = cyc;
                e.lat  = lat;
                sb.push_back(e);
                n_hs++;
                @(posedge i_clk);
                #1;
                break;
            end
            @(posedge i_clk);
            #1;
            tries++;
            if (tries > 200) begin
                n_checks++;
                n_fail++;
                $display("FAIL send_timeout: o_ready never rose (t=%0t)", $time);
                break;
            end
        end
    endtask

    // Non-valid cycles carry garbage data that must have no effect.
    task automatic idle();
        i_valid    = 1'b0;
        i_fpu_op   = 1'($urandom);
        i_sign_a   = 1'($urandom);
        i_sign_b   = 1'($urandom);
        i_carry    = 1'($urandom);
        i_E_zero_A = 1'($urandom);
        i_E_zero_B = 1'($urandom);
        i_man_max  = 24'($urandom);
        i_man_min  = 24'($urandom);
    endtask

    task automatic wait_drain(input string name);
        int i;
        i = 0;
        while (sb.size() != 0 && i < 200) begin
            @(posedge i_clk);
            i++;
        end
        @(posedge i_clk);
        #1;
        check(name, 64'(sb.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"},    64'(o_valid),    64'd0);
        check({tag, "_man"},      64'(o_man_alu),  64'd0);
        check({tag, "_ovf"},      64'(o_overflow), 64'd0);
        check({tag, "_eff_sub"},  64'(o_eff_sub),  64'd0);
        check({tag, "_lzc"},      64'(o_lzc),      64'd0);
    endtask

    // Monitor: compare each transferred output beat against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (i_rst_n && o_valid && i_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got man=%0h with empty scoreboard (t=%0t)",
                             o_man_alu, $time);
                end else begin
                    e = sb.pop_front();
                    check("man",     64'(o_man_alu),  64'(e.man));
                    check("ovf",     64'(o_overflow), 64'(e.ovf));
                    check("eff_sub", 64'(o_eff_sub),  64'(e.es));
                    check("lzc",     64'(o_lzc),      64'(e.lzc));
                    if (e.lat) check("latency", 64'(cyc), 64'(e.t_hs + NUM_STAGE));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_rst_n = 1'b0;
        i_ready = 1'b1;
        idle();
        repeat (3) @(posedge i_clk);
        #1;
        check_reset_outputs("reset");
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        check("ready_after_reset", 64'(o_ready), 64'd1);

        // Directed beats, back to back, no backpressure.
        //    op sa sb c  eA eB max        min        exp_man    ovf es lzc lat
        send(0, 0, 0, 0, 0, 0, 24'h800000, 24'h800000, 24'h000000, 1, 0, 24, 1);
        send(1, 0, 0, 0, 0, 0, 24'hC00000, 24'h800000, 24'h400000, 0, 1,  1, 1);
        send(1, 0, 0, 1, 0, 0, 24'hC00000, 24'h800000, 24'h3FFFFF, 0, 1,  2, 1);
        send(0, 0, 1, 0, 0, 0, 24'hA00000, 24'h200000, 24'h800000, 0, 1,  0, 1);
        send(0, 0, 0, 0, 0, 1, 24'h912345, 24'h000000, 24'h912345, 0, 0,  0, 1);
        send(0, 0, 0, 0, 1, 0, 24'h800000, 24'h123456, 24'h123456, 0, 0,  3, 1);
        send(1, 0, 0, 0, 1, 1, 24'h800000, 24'h000000, 24'h000000, 0, 1, 24, 1);
        send(1, 0, 0, 0, 0, 0, 24'h800000, 24'h800000, 24'h000000, 0, 1, 24, 1);
        send(0, 1, 1, 0, 0, 0, 24'hFFFFFF, 24'h000001, 24'h000000, 1, 0, 24, 1);
        send(0, 0, 0, 1, 0, 0, 24'h400000, 24'h400000, 24'h800000, 0, 0,  0, 1);
        send(0, 0, 0, 0, 1, 0, 24'h800001, 24'h000001, 24'h800002, 0, 0,  0, 1);
        send(1, 1, 0, 0, 0, 0, 24'h300000, 24'h100000, 24'h400000, 0, 0,  1, 1);
        idle();
        wait_drain("drain_directed");

        // Backpressure: 8 beats offered while the consumer stalls 5 cycles.
        begin
            int hs0;
            hs0     = n_hs;
            i_ready = 1'b0;
            fork
                begin
                    for (int k = 0; k < 8; k++) begin
                        send(0, 0, 0, 0, 0, 0, 24'h400000 | 24'(k), 24'h100000,
                             24'h500000 | 24'(k), 0, 0, 1, 0);
                    end
                    idle();
                end
                begin
                    repeat (NUM_STAGE + 1) @(negedge i_clk);
                    check("bp_accepted", 64'(n_hs - hs0), 64'(NUM_STAGE));
                    for (int j = 0; j < 2; j++) begin
                        @(negedge i_clk);
                        check("bp_ready_low",   64'(o_ready),   64'd0);
                        check("bp_valid_held",  64'(o_valid),   64'd1);
                        check("bp_data_stable", 64'(o_man_alu), 64'h500000);
                    end
                    @(posedge i_clk);
                    #1;
                    i_ready = 1'b1;
                end
            join
        end
        wait_drain("drain_backpressure");

        // Reset with a full pipeline: in-flight beats must vanish.
        i_ready = 1'b0;
        for (int k = 0; k < NUM_STAGE; k++) begin
            send(0, 0, 0, 0, 0, 0, 24'h200000, 24'h200000, 24'h400000, 0, 0, 1, 0);
        end
        idle();
        check("full_before_reset", 64'(o_valid), 64'd1);
        i_rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        sb.delete();
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        check("ready_after_mid_reset", 64'(o_ready), 64'd1);
        send(1, 0, 0, 0, 0, 0, 24'h900000, 24'h100000, 24'h800000, 0, 1, 0, 1);
        idle();
        wait_drain("drain_after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
